ft2232h_frame_packetizer: RTL and testbench
===========================================

# ft2232h_frame_packetizer

Buffers DAQ sample frames and serialises them into framed byte packets for the FT2232H synchronous-FIFO write stage. Sits directly upstream of the FT245 synchronous writer and feeds it one byte per accepted handshake. Provides sync header, sequence number and checksum so host software can realign and detect loss. Drops whole frames on overflow, never partial ones.

## Interface
- CHANNELS, 8: samples per frame; ≥1.
- FIFO_DEPTH, 16: sample FIFO depth; power of 2, ≥ CHANNELS.
- SYNC0, 8'hA5: first header byte.
- SYNC1, 8'h5A: second header byte.

- clk_i  in  1  60 MHz CLKOUT from FT2232H; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- sample_i  in  16  sample data.
- sample_valid_i  in  1  sample_i valid this cycle; no backpressure.
- sample_first_i  in  1  qualifies channel-0 sample of a frame.
- byte_o  out  8  packet byte to writer.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  writer accepts byte (TXE low, WR asserted).
- overflow_o  out  1  sticky: ≥1 frame dropped since reset.
- dropped_o  out  16  dropped-frame count, saturates at 16'hFFFF.
- busy_o  out  1  packet in progress (state ≠ IDLE).
- fifo_count_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Packet: SYNC0, SYNC1, SEQ, then CHANNELS samples each MSB then LSB, then CSUM. Length 4+2·CHANNELS bytes.
- CSUM = 8-bit mod-256 sum of SEQ and all sample bytes (sync bytes excluded).
- SEQ: 8-bit, reset 0, increments when CSUM accepted, wraps 255→0.
- Input admission: on sample_valid_i & sample_first_i, if (FIFO_DEPTH − fifo_count) ≥ CHANNELS in that cycle (same-cycle pop not credited), frame is accepted: this and following valid samples pushed until the next sample_first_i. Otherwise frame dropped: this and following samples discarded, overflow_o set, dropped_o incremented once.
- Valid samples before any first-qualified sample after reset are discarded, not counted.
- A frame with more than CHANNELS samples: excess samples discarded; frame with fewer: next sample_first_i starts new frame, no padding (host detects via CSUM).
- Push and pop in same cycle: occupancy unchanged; both data movements occur.
- Transfer = byte_valid_o & byte_ready_i. byte_o and byte_valid_o held stable until transfer.
- FSM states: IDLE, SYNC0, SYNC1, SEQ, MSB, LSB, CSUM.
  - IDLE → SYNC0 when fifo_count ≥ CHANNELS.
  - SYNC0 → SYNC1 → SEQ → MSB on transfer.
  - MSB → LSB on transfer; LSB pops FIFO on transfer; LSB → MSB if samples remaining, else → CSUM.
  - CSUM → IDLE on transfer.
- byte_valid_o high in all states except IDLE.
- Reset values: byte_valid_o 0, byte_o 0, overflow_o 0, dropped_o 0, busy_o 0, fifo_count_o 0, SEQ 0, state IDLE, FIFO empty, admission state "no frame".

## Timing
- byte_o, byte_valid_o registered; IDLE decision uses registered fifo_count.
- First byte: byte_valid_o rises 1 cycle after the cycle fifo_count first reads ≥ CHANNELS (i.e. 2 cycles after the push that completed the frame).
- Full-rate throughput: with byte_ready_i held high, one byte per cycle, 4+2·CHANNELS cycles per packet, plus exactly 1 IDLE cycle (byte_valid_o low) between packets.
- byte_ready_i low: state, byte_o, CSUM accumulator frozen; input side continues.
- rst_i mid-packet: next cycle all outputs at reset values; partial packet abandoned; no completion bytes sent.
- Sample in FIFO-full cycle with frame accepted cannot occur by admission rule; if it does (protocol violation), sample dropped, overflow_o set.

## Test plan
- CHANNELS=4, frame 0x1234,0xABCD,0x0001,0xFF00, ready high → bytes A5 5A 00 12 34 AB CD 00 01 FF 00 BE, then byte_valid_o low 1 cycle.
- Same frame, byte_ready_i random 50% → identical byte sequence; byte_o stable while valid & !ready.
- 256+2 back-to-back frames → SEQ 00..FF, 00, 01; CSUM correct each packet.
- Ready held low, frames pushed until FIFO_DEPTH=16 holds 16 samples, then 2 more frames → both dropped, overflow_o=1, dropped_o=2; after draining, new frames packetised with contiguous SEQ.
- FIFO at 12 with ready high, new first sample arrives same cycle as pop → frame admitted only if free ≥4 computed pre-pop (12 → admitted); occupancy stays 12 on simultaneous push/pop.
- rst_i asserted during MSB of sample 2 → next cycle byte_valid_o=0, fifo_count_o=0, SEQ=0; next frame yields packet with SEQ 00.

Source files
------------

// File: rtl/ft2232h_frame_packetizer.sv
// ft2232h_frame_packetizer
//
// Buffers DAQ sample frames in a small FIFO and serialises each complete
// frame into a byte packet for the FT2232H synchronous-FIFO writer:
//   SYNC0, SYNC1, SEQ, {sample MSB, sample LSB} x CHANNELS, CSUM
// CSUM is the mod-256 sum of SEQ and every sample byte. A frame is only
// admitted when the FIFO has room for a whole frame; otherwise the entire
// frame is dropped and counted, so the host never sees a partial frame.
//
// Ports
//   clk_i           60 MHz CLKOUT, rising edge
//   rst_i           synchronous active-high reset
//   sample_i        16-bit sample
//   sample_valid_i  sample_i valid this cycle (no backpressure)
//   sample_first_i  marks channel-0 sample of a frame
//   byte_o          packet byte to writer (registered)
//   byte_valid_o    byte_o valid (registered)
//   byte_ready_i    writer accepts byte this cycle
//   overflow_o      sticky: at least one frame dropped since reset
//   dropped_o       dropped-frame count, saturating
//   busy_o          packet in progress
//   fifo_count_o    FIFO occupancy in samples
module ft2232h_frame_packetizer #(
  parameter int         CHANNELS   = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [15:0]                   sample_i,
  input  logic                          sample_valid_i,
  input  logic                          sample_first_i,
  output logic [7:0]                    byte_o,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  output logic                          overflow_o,
  output logic [15:0]                   dropped_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CH_W  = $clog2(CHANNELS + 1);

  // Highest occupancy at which a whole new frame still fits.
  localparam logic [CNT_W-1:0] ADMIT_MAX = CNT_W'(FIFO_DEPTH - CHANNELS);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(CHANNELS);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_W-1:0]  CH_MAX    = CH_W'(CHANNELS);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC0, ST_SYNC1, ST_SEQ, ST_MSB, ST_LSB, ST_CSUM
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0]      mem_q [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             acc_q, acc_d;
  logic [CH_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      dropped_q, dropped_d;
  logic             push, pop, xfer;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;

  assign xfer = valid_q & byte_ready_i;
  assign pop  = (state_q == ST_LSB) & xfer;

  // Input admission: decision uses pre-pop occupancy.
  always_comb begin
    acc_d       = acc_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    dropped_d   = dropped_q;
    push        = 1'b0;
    if (sample_valid_i) begin
      if (sample_first_i) begin
        if (count_q <= ADMIT_MAX) begin
          acc_d       = 1'b1;
          frame_cnt_d = CH_W'(1);
          push        = 1'b1;
        end else begin
          acc_d      = 1'b0;
          overflow_d = 1'b1;
          dropped_d  = sat_inc16(dropped_q);
        end
      end else if (acc_q && (frame_cnt_q < CH_MAX)) begin
        frame_cnt_d = frame_cnt_q + CH_W'(1);
        push        = 1'b1;
      end
    end
    // Defensive: a push into a full FIFO is discarded and flagged.
    if (push && (count_q == FULL_CNT)) begin
      push       = 1'b0;
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        smp_cnt_d = '0;
        if (count_q >= FRAME_CNT) state_d = ST_SYNC0;
      end
      ST_SYNC0: if (xfer) state_d = ST_SYNC1;
      ST_SYNC1: if (xfer) state_d = ST_SEQ;
      ST_SEQ:   if (xfer) state_d = ST_MSB;
      ST_MSB:   if (xfer) state_d = ST_LSB;
      ST_LSB: begin
        if (xfer) begin
          if (smp_cnt_q == CH_LAST) begin
            state_d = ST_CSUM;
          end else begin
            state_d   = ST_MSB;
            smp_cnt_d = smp_cnt_q + CH_W'(1);
          end
        end
      end
      ST_CSUM:  if (xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Checksum/sequence bookkeeping; the checksum restarts with SEQ.
  always_comb begin
    csum_d = csum_q;
    seq_d  = seq_q;
    if (xfer) begin
      unique case (state_q)
        ST_SEQ:         csum_d = byte_q;
        ST_MSB, ST_LSB: csum_d = csum_q + byte_q;
        ST_CSUM:        seq_d  = seq_q + 8'd1;
        default:        csum_d = csum_q;
      endcase
    end
  end

  // Output: byte register is loaded with the byte belonging to the next
  // state, so byte_o always matches state_q. A stalled byte is held.
  always_comb begin
    valid_d = (state_d != ST_IDLE);
    byte_d  = 8'h00;
    if (valid_q && !byte_ready_i) begin
      byte_d = byte_q;
    end else begin
      unique case (state_d)
        ST_SYNC0: byte_d = SYNC0;
        ST_SYNC1: byte_d = SYNC1;
        ST_SEQ:   byte_d = seq_q;
        ST_MSB:   byte_d = mem_q[rd_ptr_d][15:8];
        ST_LSB:   byte_d = mem_q[rd_ptr_d][7:0];
        ST_CSUM:  byte_d = csum_d;
        default:  byte_d = 8'h00;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Control and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= 1'b0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      dropped_q   <= '0;
      seq_q       <= 8'h00;
      byte_q      <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
      seq_q       <= seq_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
    end
  end

  // Data storage: contents are qualified by pointers and the FSM.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= sample_i;
    csum_q <= csum_d;
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign overflow_o   = overflow_q;
  assign dropped_o    = dropped_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_ft2232h_frame_packetizer.sv
// Testbench for ft2232h_frame_packetizer with CHANNELS=4, FIFO_DEPTH=16.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. after the edge has settled.
module tb_ft2232h_frame_packetizer;

  localparam int CH      = 4;
  localparam int DEPTH   = 16;
  localparam int PKT_LEN = 4 + 2 * CH;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] sample_i = 16'h0;
  logic        sample_valid_i = 1'b0;
  logic        sample_first_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b0;
  logic        overflow_o;
  logic [15:0] dropped_o;
  logic        busy_o;
  logic [4:0]  fifo_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pkt_buf [PKT_LEN];

  always #5 clk = ~clk;

  ft2232h_frame_packetizer #(
    .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .SYNC0(8'hA5), .SYNC1(8'h5A)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .sample_first_i(sample_first_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
    .overflow_o(overflow_o), .dropped_o(dropped_o), .busy_o(busy_o),
    .fifo_count_o(fifo_count_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_csum(input logic [7:0] seq,
      input logic [15:0] a, input logic [15:0] b,
      input logic [15:0] c, input logic [15:0] d);
    logic [7:0] s;
    s = seq + a[15:8] + a[7:0] + b[15:8] + b[7:0]
            + c[15:8] + c[7:0] + d[15:8] + d[7:0];
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3);
    logic [15:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      sample_i       = s[i];
      sample_valid_i = 1'b1;
      sample_first_i = (i == 0);
      step();
    end
    sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
  endtask

  task automatic collect_packet(output bit ok);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < PKT_LEN && guard < 200) begin
      if (byte_valid_o && byte_ready_i) begin
        pkt_buf[idx] = byte_o;
        idx++;
      end
      step();
      guard++;
    end
    ok = (idx == PKT_LEN);
  endtask

  task automatic wait_idle(output bit ok);
    int guard;
    guard = 0;
    while (byte_valid_o && guard < 100) begin
      step();
      guard++;
    end
    ok = !byte_valid_o;
  endtask

  task automatic test_reset();
    byte_ready_i = 1'b0;
    do_reset();
    n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid: got %0b want 0", byte_valid_o); end
    n_checks++; if (byte_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %02h want 00", byte_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
    n_checks++; if (dropped_o !== 16'h0) begin n_fail++; $display("FAIL reset_dropped: got %04h want 0000", dropped_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    n_checks++; if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_basic_packet();
    logic [7:0] exp [PKT_LEN];
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD,
            8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
    byte_ready_i = 1'b1;
    // Samples before any first-qualified sample are discarded.
    sample_i = 16'h7777; sample_valid_i = 1'b1; sample_first_i = 1'b0;
    step();
    sample_valid_i = 1'b0;
    n_checks++; if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL orphan_sample: fifo_count %0d want 0", fifo_count_o); end
    send_frame(16'h1234, 16'hABCD, 16'h0001, 16'hFF00);
    n_checks++; if (fifo_count_o !== 5'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", fifo_count_o); end
    n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: valid %0b want 0", byte_valid_o); end
    for (int i = 0; i < PKT_LEN; i++) begin
      step();
      n_checks++;
      if (byte_valid_o !== 1'b1 || byte_o !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_byte[%0d]: got valid=%0b byte=%02h want valid=1 byte=%02h", i, byte_valid_o, byte_o, exp[i]);
      end
    end
    step();
    n_checks++; if (byte_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_gap: valid=%0b busy=%0b want 0 0", byte_valid_o, busy_o); end
    n_checks++; if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL basic_drained: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_random_ready();
    logic [7:0] exp [PKT_LEN];
    logic [7:0] got [PKT_LEN];
    logic [7:0] prev_byte;
    bit         prev_hold;
    bit         r;
    int         idx;
    int         guard;
    exp = '{8'hA5, 8'h5A, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD,
            8'h00, 8'h01, 8'hFF, 8'h00, 8'hBF};
    for (int i = 0; i < PKT_LEN; i++) got[i] = 8'h00;
    byte_ready_i = 1'b0;
    send_frame(16'h1234, 16'hABCD, 16'h0001, 16'hFF00);
    prev_hold = 1'b0; prev_byte = 8'h00; idx = 0; guard = 0;
    while (idx < PKT_LEN && guard < 400) begin
      if (prev_hold) begin
        n_checks++;
        if (byte_valid_o !== 1'b1 || byte_o !== prev_byte) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%0b byte=%02h want valid=1 byte=%02h", byte_valid_o, byte_o, prev_byte);
        end
      end
      r = 1'($urandom_range(0, 1));
      byte_ready_i = r;
      if (byte_valid_o && r) begin
        got[idx] = byte_o;
        idx++;
      end
      prev_hold = byte_valid_o && !r;
      prev_byte = byte_o;
      step();
      guard++;
    end
    byte_ready_i = 1'b1;
    n_checks++; if (idx != PKT_LEN) begin n_fail++; $display("FAIL random_timeout: got %0d bytes want %0d", idx, PKT_LEN); end
    for (int i = 0; i < PKT_LEN; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL random_byte[%0d]: got %02h want %02h", i, got[i], exp[i]);
      end
    end
    n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL random_idle: valid %0b want 0", byte_valid_o); end
  endtask

  task automatic test_seq_wrap();
    logic [7:0]  k8;
    logic [15:0] s0, s1, s2, s3;
    logic [7:0]  want;
    bit          ok;
    do_reset();
    byte_ready_i = 1'b1;
    for (int k = 0; k < 258; k++) begin
      k8 = k[7:0];
      s0 = {k8, 8'h11};
      s1 = {8'h3C, ~k8};
      s2 = {k8 + 8'd7, k8};
      s3 = 16'hFE02;
      send_frame(s0, s1, s2, s3);
      collect_packet(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL wrap_timeout: packet %0d incomplete", k);
      end else begin
        want = exp_csum(k8, s0, s1, s2, s3);
        n_checks++;
        if (pkt_buf[0] !== 8'hA5 || pkt_buf[1] !== 8'h5A) begin n_fail++; $display("FAIL wrap_sync[%0d]: got %02h %02h want A5 5A", k, pkt_buf[0], pkt_buf[1]); end
        n_checks++;
        if (pkt_buf[2] !== k8) begin n_fail++; $display("FAIL wrap_seq[%0d]: got %02h want %02h", k, pkt_buf[2], k8); end
        n_checks++;
        if (pkt_buf[PKT_LEN-1] !== want) begin n_fail++; $display("FAIL wrap_csum[%0d]: got %02h want %02h", k, pkt_buf[PKT_LEN-1], want); end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    byte_ready_i = 1'b1;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 8; i++) step();
    n_checks++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h33) begin n_fail++; $display("FAIL midrst_pos: got valid=%0b byte=%02h want 1 33", byte_valid_o, byte_o); end
    rst_i = 1'b1;
    step();
    n_checks++; if (byte_valid_o !== 1'b0 || byte_o !== 8'h00) begin n_fail++; $display("FAIL midrst_out: got valid=%0b byte=%02h want 0 00", byte_valid_o, byte_o); end
    n_checks++; if (fifo_count_o !== 5'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_state: count=%0d busy=%0b want 0 0", fifo_count_o, busy_o); end
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_abandon[%0d]: valid %0b want 0", i, byte_valid_o); end
    end
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    collect_packet(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_timeout: packet incomplete"); end
    n_checks++; if (pkt_buf[2] !== 8'h00) begin n_fail++; $display("FAIL midrst_seq: got %02h want 00", pkt_buf[2]); end
    n_checks++; if (pkt_buf[PKT_LEN-1] !== 8'h54) begin n_fail++; $display("FAIL midrst_csum: got %02h want 54", pkt_buf[PKT_LEN-1]); end
  endtask

  task automatic test_overflow();
    bit         ok;
    logic [7:0] tag;
    logic [7:0] want;
    do_reset();
    byte_ready_i = 1'b0;
    for (int f = 0; f < 4; f++) begin
      tag = 8'hC0 | 8'(f);
      send_frame({tag, 8'h10}, 16'h0203, 16'h0405, 16'h0607);
    end
    n_checks++; if (fifo_count_o !== 5'd16) begin n_fail++; $display("FAIL ovf_full_count: got %0d want 16", fifo_count_o); end
    n_checks++; if (overflow_o !== 1'b0 || dropped_o !== 16'd0) begin n_fail++; $display("FAIL ovf_premature: overflow=%0b dropped=%0d want 0 0", overflow_o, dropped_o); end
    send_frame(16'hD010, 16'h0203, 16'h0405, 16'h0607);
    send_frame(16'hD110, 16'h0203, 16'h0405, 16'h0607);
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", overflow_o); end
    n_checks++; if (dropped_o !== 16'd2) begin n_fail++; $display("FAIL ovf_dropped: got %0d want 2", dropped_o); end
    n_checks++; if (fifo_count_o !== 5'd16) begin n_fail++; $display("FAIL ovf_count_after_drop: got %0d want 16", fifo_count_o); end
    byte_ready_i = 1'b1;
    for (int f = 0; f < 5; f++) begin
      tag = 8'hC0 | 8'(f);
      if (f == 4) send_frame({tag, 8'h10}, 16'h0203, 16'h0405, 16'h0607);
      collect_packet(ok);
      want = exp_csum(8'(f), {tag, 8'h10}, 16'h0203, 16'h0405, 16'h0607);
      n_checks++;
      if (!ok || pkt_buf[2] !== 8'(f) || pkt_buf[3] !== tag || pkt_buf[PKT_LEN-1] !== want) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: ok=%0b seq=%02h tag=%02h csum=%02h want seq=%02h tag=%02h csum=%02h",
                 f, ok, pkt_buf[2], pkt_buf[3], pkt_buf[PKT_LEN-1], 8'(f), tag, want);
      end
    end
    n_checks++; if (overflow_o !== 1'b1 || dropped_o !== 16'd2) begin n_fail++; $display("FAIL ovf_sticky: overflow=%0b dropped=%0d want 1 2", overflow_o, dropped_o); end
  endtask

  task automatic test_push_pop_same_cycle();
    bit         ok;
    logic [7:0] tag;
    logic [7:0] want;
    logic [7:0] exp_pre [4];
    exp_pre = '{8'h5A, 8'h00, 8'hE0, 8'h21};
    do_reset();
    byte_ready_i = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tag = 8'hE0 | 8'(f);
      send_frame({tag, 8'h21}, 16'h4321, 16'h8765, 16'h0F0F);
    end
    n_checks++; if (fifo_count_o !== 5'd12) begin n_fail++; $display("FAIL pp_setup_count: got %0d want 12", fifo_count_o); end
    byte_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (byte_o !== exp_pre[i]) begin n_fail++; $display("FAIL pp_pre[%0d]: got %02h want %02h", i, byte_o, exp_pre[i]); end
    end
    // Now in the LSB state: the next edge pops while the new frame starts.
    sample_i = 16'hE321; sample_valid_i = 1'b1; sample_first_i = 1'b1;
    step();
    n_checks++; if (fifo_count_o !== 5'd12) begin n_fail++; $display("FAIL pp_count: got %0d want 12", fifo_count_o); end
    sample_first_i = 1'b0;
    sample_i = 16'h4321; step();
    sample_i = 16'h8765; step();
    sample_i = 16'h0F0F; step();
    sample_valid_i = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pp_idle_timeout: first packet never ended"); end
    for (int f = 1; f < 4; f++) begin
      tag = 8'hE0 | 8'(f);
      collect_packet(ok);
      want = exp_csum(8'(f), {tag, 8'h21}, 16'h4321, 16'h8765, 16'h0F0F);
      n_checks++;
      if (!ok || pkt_buf[2] !== 8'(f) || pkt_buf[3] !== tag || pkt_buf[PKT_LEN-1] !== want) begin
        n_fail++;
        $display("FAIL pp_packet[%0d]: ok=%0b seq=%02h tag=%02h csum=%02h want seq=%02h tag=%02h csum=%02h",
                 f, ok, pkt_buf[2], pkt_buf[3], pkt_buf[PKT_LEN-1], 8'(f), tag, want);
      end
    end
    n_checks++; if (overflow_o !== 1'b0 || dropped_o !== 16'd0) begin n_fail++; $display("FAIL pp_no_drop: overflow=%0b dropped=%0d want 0 0", overflow_o, dropped_o); end
  endtask

  initial begin
    step();
    test_reset();
    test_basic_packet();
    test_random_ready();
    test_seq_wrap();
    test_reset_mid_packet();
    test_overflow();
    test_push_pop_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
